fetch_pc_bht: RTL
=================

# fetch_pc_bht

Fetch-stage front end: holds the program counter, looks up a direct-mapped branch history table (BHT) with the current PC, and selects the next PC from the predicted target, sequential PC+4, or a redirect from execute. Sits directly upstream of the IF/ID register. Its `pc` output drives instruction memory, and `bht_state` feeds that register's `bht_state_in`. Predictor training arrives from the execute stage using the 2-bit state carried down the pipeline.

## Interface
- `BHT_ENTRIES`, 16: number of entries; power of two, ≥2. `IDX_W` = log2(`BHT_ENTRIES`).
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: fetch enable; 0 holds the PC (stall).
- `redirect` in 1: misprediction or jump correction from execute.
- `redirect_pc` in 32: corrected PC, used when `redirect`=1.
- `upd_valid` in 1: resolved branch update strobe.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_taken` in 1: actual outcome of the resolved branch.
- `upd_target` in 32: actual taken target.
- `upd_state` in 2: BHT state predicted for that branch, carried down the pipeline.
- `pc` out 32: current fetch PC (registered).
- `bht_state` out 2: counter for `pc` (combinational); 2'b00 on a miss.
- `pred_taken` out 1: `hit` && `bht_state[1]`.

## Operation
- Entry fields:
  - `valid` 1
  - `tag` (30−`IDX_W` bits)
  - `target` 30 bits (word address)
  - `cnt` 2
- Address split:
  - index = `pc[IDX_W+1:2]`
  - tag = `pc[31:IDX_W+2]`
  - `pc[1:0]` ignored.
- Lookup:
  - `hit` = valid[index] && tag match.
  - `bht_state` = `hit` ? cnt : 2'b00.
- Next-PC priority:
  1. `redirect` → `redirect_pc`. Wins even when `en`=0.
  2. else `en`=0 → hold `pc`.
  3. else `pred_taken` → {target, 2'b00}.
  4. else `pc`+4, modulo 2^32 (32'hFFFF_FFFC → 0).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Saturating.
- Update, on an edge with `upd_valid`=1, indexed by `upd_pc`:
  - Tag hit: `cnt` ← `upd_taken` ? sat(`upd_state`+1) : sat(`upd_state`−1). If `upd_taken`, also `target` ← `upd_target[31:2]`.
  - Miss and `upd_taken`=1: allocate/replace with valid=1, tag, target, `cnt`=2'b10.
  - Miss and `upd_taken`=0: no write.
- `upd_valid` is independent of `en` and `redirect`; the update is performed regardless.
- `redirect` does not modify the BHT.

## Timing
- Reset, asynchronous on `rst`:
  - `pc` = `RESET_PC`.
  - All `valid` = 0 and all `cnt` = 00, so `bht_state` = 0 and `pred_taken` = 0 immediately.
  - Reset mid-operation discards any in-flight update.
- Lookup is combinational on the registered `pc`. `bht_state` and `pred_taken` are valid in the same cycle as `pc`, ready for IF/ID capture at the next edge.
- `pc` changes one edge after `redirect`, `en` or a prediction is sampled. A redirect has 1-cycle latency.
- Update writes at the sampling edge and is visible to lookup from the next cycle.
- Same-cycle update and lookup of the same index: lookup returns pre-write contents (no bypass).

## Structure
- Shared header constants:
  - BHT state encodings `BHT_SNT`/`BHT_WNT`/`BHT_WT`/`BHT_ST`.
  - `RESET_PC` default.
- Sub-module `bht_table`:
  - Storage, combinational read port (index/tag → `hit`, `cnt`, `target`).
  - Synchronous write port with update/allocate logic and async clear of `valid` and `cnt`.
- Top `fetch_pc_bht`: PC register and next-PC mux.

## Test plan
- Reset: assert `rst` mid-run with `pc`=0x40 → `pc`=0x0 and `bht_state`=0 asynchronously; after release, `pc` steps 0x0, 0x4, 0x8 with `en`=1.
- Stall/redirect: `en`=0 holds `pc`=0x8 for 3 cycles. `redirect`=1, `redirect_pc`=0x100 with `en`=0 → `pc`=0x100 next cycle.
- Allocate and predict:
  - Update `upd_pc`=0x10, taken, target=0x80, state 0 → when `pc` reaches 0x10, `bht_state`=2'b10, `pred_taken`=1, next `pc`=0x80.
  - A not-taken miss update at 0x20 leaves that entry invalid.
- Saturation: repeated taken updates at 0x10 with carried states 10, 11 → `cnt` stays 11. Not-taken with state 00 → stays 00; with state 10 → 01, prediction not taken.
- Alias/replace: with `BHT_ENTRIES`=16, taken update at 0x50 (same index as 0x10, different tag) → 0x10 now misses (`bht_state`=0, next `pc`=0x14).
- Same-cycle hazard and wrap: an update to the index being looked up returns old `cnt` that cycle and the new value the next. `pc`=0xFFFF_FFFC with a miss → next `pc`=0x0.

Source files
------------

// File: rtl/fetch_pc_bht_pkg.sv
// ============================================================================
// Module : fetch_pc_bht_pkg
// Brief  : Shared BHT state encodings, reset PC default and counter training.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pc_bht_pkg;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_e;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    // Saturating 2-bit counter step, applied to the state carried down the pipe.
    function automatic logic [1:0] bht_train(input logic [1:0] state, input logic taken);
        logic [1:0] result;
        result = state;
        if (taken) begin
            if (state != BHT_ST) begin
                result = state + 2'd1;
            end
        end else begin
            if (state != BHT_SNT) begin
                result = state - 2'd1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc_bht_bht_table.sv
// ============================================================================
// Module : bht_table
// Brief  : Direct-mapped branch history table, async read, sync update/allocate.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bht_table
    import fetch_pc_bht_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BHT_ENTRIES),
    parameter int TAG_W       = 30 - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [TAG_W-1:0]  i_rd_tag,
    output logic              o_rd_hit,
    output logic [1:0]        o_rd_cnt,
    output logic [29:0]       o_rd_target,
    input  logic              i_wr_valid,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic              i_wr_taken,
    input  logic [29:0]       i_wr_target,
    input  logic [1:0]        i_wr_state
);

    logic [BHT_ENTRIES-1:0] r_valid;
    logic [1:0]             r_cnt    [BHT_ENTRIES];
    logic [TAG_W-1:0]       r_tag    [BHT_ENTRIES];
    logic [29:0]            r_target [BHT_ENTRIES];

    logic       w_wr_hit;
    logic       w_alloc;
    logic       w_cnt_we;
    logic       w_tgt_we;
    logic [1:0] w_cnt_new;

    assign o_rd_hit    = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_cnt    = r_cnt[i_rd_idx];
    assign o_rd_target = r_target[i_rd_idx];

    // A not-taken miss writes nothing; a taken miss allocates as weak-taken.
    assign w_wr_hit  = r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag);
    assign w_alloc   = i_wr_valid && !w_wr_hit && i_wr_taken;
    assign w_cnt_we  = i_wr_valid && (w_wr_hit || i_wr_taken);
    assign w_tgt_we  = i_wr_valid && i_wr_taken;
    assign w_cnt_new = w_wr_hit ? bht_train(i_wr_state, i_wr_taken) : BHT_WT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_cnt[i] <= BHT_SNT;
            end
        end else begin
            if (w_alloc) begin
                r_valid[i_wr_idx] <= 1'b1;
            end
            if (w_cnt_we) begin
                r_cnt[i_wr_idx] <= w_cnt_new;
            end
        end
    end

    // Tag and target are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
        if (w_tgt_we) begin
            r_target[i_wr_idx] <= i_wr_target;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_bht.sv
// ============================================================================
// Module : fetch_pc_bht
// Brief  : Fetch PC register with BHT lookup and next-PC selection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_pc_bht
    import fetch_pc_bht_pkg::*;
#(
    parameter int          BHT_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = c_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic [1:0]  upd_state,
    output logic [31:0] pc,
    output logic [1:0]  bht_state,
    output logic        pred_taken
);

    localparam int c_IDX_W = $clog2(BHT_ENTRIES);
    localparam int c_TAG_W = 30 - c_IDX_W;

    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        w_hit;
    logic [1:0]  w_cnt;
    logic [29:0] w_target;
    logic        w_unused_bits;

    bht_table #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .IDX_W       (c_IDX_W),
        .TAG_W       (c_TAG_W)
    ) u_bht_table (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (r_pc[c_IDX_W+1:2]),
        .i_rd_tag    (r_pc[31:c_IDX_W+2]),
        .o_rd_hit    (w_hit),
        .o_rd_cnt    (w_cnt),
        .o_rd_target (w_target),
        .i_wr_valid  (upd_valid),
        .i_wr_idx    (upd_pc[c_IDX_W+1:2]),
        .i_wr_tag    (upd_pc[31:c_IDX_W+2]),
        .i_wr_taken  (upd_taken),
        .i_wr_target (upd_target[31:2]),
        .i_wr_state  (upd_state)
    );

    assign w_unused_bits = ^{upd_pc[1:0], upd_target[1:0]};

    assign pc         = r_pc;
    assign bht_state  = w_hit ? w_cnt : BHT_SNT;
    assign pred_taken = w_hit && w_cnt[1];

    // Redirect outranks a stall so execute corrections are never lost.
    always_comb begin
        w_next_pc = r_pc;
        if (redirect) begin
            w_next_pc = redirect_pc;
        end else if (!en) begin
            w_next_pc = r_pc;
        end else if (pred_taken) begin
            w_next_pc = {w_target, 2'b00};
        end else begin
            w_next_pc = r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

endmodule

`default_nettype wire
